// File: rtl/matriz_leds_cfg.sv
// matriz_leds_cfg: ROWS x COLS puzzle LED board with loadable per-button toggle masks and a level-limited row scan.
// Define MATRIZ_MOVE_COUNTER_EN to count applied presses on movimentos; otherwise movimentos is tied to 0.
module matriz_leds_cfg #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int N_BTN = 8,
    parameter int LVL_W = 3,
    parameter int SCAN_DIV = 1000,
    parameter int MOVES_W = 10,
    localparam int BW = (N_BTN > 1) ? $clog2(N_BTN) : 1,
    localparam int RW = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_BTN-1:0]   botoes,
    input  logic [LVL_W-1:0]   nivel,
    input  logic               clear,
    input  logic               cfg_we,
    input  logic [BW-1:0]      cfg_btn,
    input  logic [RW-1:0]      cfg_row,
    input  logic [COLS-1:0]    cfg_mask,
    output logic               nivel_concluido,
    output logic [COLS-1:0]    colunas,
    output logic [ROWS-1:0]    linhas,
    output logic [RW-1:0]      indice,
    output logic               press,
    output logic [MOVES_W-1:0] movimentos
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int AW = (LVL_W + 1 > RW + 1) ? LVL_W + 1 : RW + 1;
    logic [N_BTN-1:0] s1, s2, prev, edg;
    logic [COLS-1:0] board [ROWS];
    logic [COLS-1:0] mask [N_BTN][ROWS];
    logic [COLS-1:0] tog [ROWS];
    logic [RW-1:0] row;
    logic [CW-1:0] cnt;
    logic [AW-1:0] lv, n_act;
    logic win_c, row_ok, last, cfg_ok;
    assign edg = s2 & ~prev;
    assign lv = AW'({nivel, 1'b1});
    assign n_act = (lv > AW'(ROWS)) ? AW'(ROWS) : lv;
    assign row_ok = AW'(row) < n_act;
    assign last = cnt == CW'(SCAN_DIV - 1);
    assign cfg_ok = cfg_we && ({1'b0, cfg_btn} < (BW + 1)'(N_BTN)) && ({1'b0, cfg_row} < (RW + 1)'(ROWS));
    assign linhas = ROWS'(1) << row;
    assign indice = row;
    // A row left out of range by a level change stays dark until the scan snaps back to row 0
    assign colunas = row_ok ? ~board[row] : '1;
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            tog[r] = '0;
            for (int b = 0; b < N_BTN; b++)
                tog[r] = tog[r] ^ (edg[b] ? mask[b][r] : '0);
        end
    end
    always_comb begin
        win_c = 1'b1;
        for (int r = 0; r < ROWS; r++)
            if (AW'(r) < n_act && board[r] != '1) win_c = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            prev <= '0;
            press <= 1'b0;
            nivel_concluido <= 1'b0;
        end else begin
            s1 <= botoes;
            s2 <= s1;
            prev <= s2;
            press <= |edg && !clear;
            nivel_concluido <= win_c;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst || !row_ok) begin
            row <= '0;
            cnt <= '0;
        end else if (last) begin
            cnt <= '0;
            row <= (AW'(row) + AW'(1) >= n_act) ? '0 : row + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++)
            board[r] <= (!rst || clear) ? '0 : board[r] ^ tog[r];
    end
    // Mask update lands at the same edge as a toggle, so that toggle still sees the old entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < N_BTN; b++)
                for (int r = 0; r < ROWS; r++)
                    mask[b][r] <= '0;
        end else if (cfg_ok) begin
            mask[cfg_btn][cfg_row] <= cfg_mask;
        end
    end
`ifdef MATRIZ_MOVE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (!rst || clear) movimentos <= '0;
        else if (press && movimentos != '1) movimentos <= movimentos + 1'b1;
    end
`else
    assign movimentos = '0;
`endif
endmodule

// File: doc/matriz_leds_cfg.md
Name: matriz_leds_cfg

Overview:
Parametrised successor to the fixed 8x8 puzzle LED-matrix controller. It holds a ROWS x COLS virtual LED board and toggles LEDs on debounced button press edges, using a run-time loadable per-button toggle-mask table. It scans the rows active for the current level at a programmable dwell rate and flags level completion to the control unit. It sits between the synchronised button inputs / UC and the physical matrix drivers.

Parameters:
ROWS, 8, number of matrix rows (2..16)
COLS, 8, number of matrix columns (2..16)
N_BTN, 8, number of puzzle buttons (1..16)
LVL_W, 3, width of level input
SCAN_DIV, 1000, clocks each row is driven before advancing (>=1)
MOVES_W, 10, move-counter width (optional feature)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low
botoes  in  N_BTN  raw button levels, asynchronous to clk
nivel  in  LVL_W  current level
clear  in  1  synchronous board clear, active-high
cfg_we  in  1  mask-table write strobe
cfg_btn  in  clog2(N_BTN)  mask-table button index
cfg_row  in  clog2(ROWS)  mask-table row index
cfg_mask  in  COLS  toggle mask written to entry [cfg_btn][cfg_row]
nivel_concluido  out  1  all active rows fully lit (registered)
colunas  out  COLS  column drive, active-low (0 = LED on)
linhas  out  ROWS  one-hot active row
indice  out  clog2(ROWS)  binary index of active row
press  out  1  one-cycle pulse when at least one press edge is applied
movimentos  out  MOVES_W  move count (optional feature)

Behaviour:
- Reset (rst=0 at a clk edge): board all 0, mask table all 0, synchronisers 0, scan row 0, dwell counter 0; linhas=1, indice=0, colunas=all-ones, nivel_concluido=0, press=0, movimentos=0.
- Active rows: n_act = min(2*nivel+1, ROWS). Level 0 -> 1 row, 1 -> 3, 2 -> 5, 3 -> 7, 4 -> 8 (ROWS=8); larger levels clamp to ROWS.
- Button path: each bit passes a 2-flop synchroniser, then rising-edge detection. A held button toggles exactly once. A button high before edge E0 updates the board after edge E2 (3-cycle latency). press pulses in the same cycle as the board update.
- Toggle: on the update edge, for every row r, board[r] ^= OR-reduction... precisely board[r] ^= XOR over all buttons b with a detected edge of mask[b][r]. Simultaneous edges on several buttons are applied together in one cycle.
- Mask write: cfg_we writes mask[cfg_btn][cfg_row] at the clk edge. A press applied in the same cycle uses the old mask. Out-of-range indices are ignored.
- clear: zeroes the board at the next edge. Priority: rst > clear > toggle. Masks are preserved.
- Scan: the dwell counter counts 0..SCAN_DIV-1. At terminal count, row advances r -> r+1, wrapping to 0 after n_act-1. If nivel changes so that the current row >= new n_act, row becomes 0 and the dwell counter resets on the next edge.
- Outputs: linhas = 1<<row; indice = row; colunas = ~board[row]. Rows >= n_act are never driven.
- Win: nivel_concluido registered; it is 1 one cycle after board rows 0..n_act-1 are all-ones, and 0 otherwise. It drops one cycle after any toggle or clear breaks the condition.

Optional Feature:
MATRIZ_MOVE_COUNTER_EN
- Defined: movimentos increments by 1 on every cycle with press=1. It saturates at 2^MOVES_W-1 and is zeroed by rst or clear.
- Undefined: counter logic is absent and movimentos is driven constant 0. The port list is unchanged.

Test Plan:
- Reset, SCAN_DIV=4, nivel=2 -> linhas cycles 1,2,4,8,16,1 changing every 4 clocks; indice 0..4; colunas=all-ones throughout; nivel_concluido=0.
- Write mask[0][0]=8'hFF, nivel=0, raise botoes[0] and hold 20 cycles -> board row0=FF after third edge, press single pulse, nivel_concluido=1 one cycle later, no further toggles.
- Masks [1][0]=0F and [2][0]=3C, botoes[1] and botoes[2] rise in the same cycle -> row0=33, one press pulse, movimentos=1 (macro on).
- Board row0=FF with nivel_concluido=1, assert clear -> board 0, nivel_concluido=0 next cycle, masks intact; a second press of botoes[0] -> row0=FF again.
- nivel=4 scanning row 6, switch nivel to 1 -> next edge linhas=1, indice=0, dwell restarts; thereafter rows 0..2 only.
- cfg_we writing mask[0][0]=01 in the same cycle that botoes[0] edge is applied with old mask 80 -> row0=80; next press -> row0=81.
